// File: rtl/xbar_sw_alloc_pkg.sv
// Shared constants, types and helpers for the 5-port crossbar switch allocator.
//   NUM_CHANNEL  : input/output channel count
//   LOG_NUM_PORT : width of a port index
//   rr_add()     : modulo-NUM_CHANNEL addition for round-robin pointers
// Optional feature macro: XBAR_ALLOC_LOCK_EN (wormhole output lock), see xbar_sw_alloc.sv.
package xbar_sw_alloc_pkg;

    localparam int unsigned NUM_CHANNEL  = 5;
    localparam int unsigned LOG_NUM_PORT = 3;

    typedef logic [LOG_NUM_PORT-1:0] port_t;
    typedef logic [NUM_CHANNEL-1:0]  chan_mask_t;

    typedef enum logic {LockIdle, LockLocked} lock_state_e;

    // Both operands are expected in 0..NUM_CHANNEL-1, so one subtraction suffices.
    function automatic port_t rr_add(port_t a, port_t b);
        logic [LOG_NUM_PORT:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (LOG_NUM_PORT+1)'(NUM_CHANNEL)) begin
            s = s - (LOG_NUM_PORT+1)'(NUM_CHANNEL);
        end
        return s[LOG_NUM_PORT-1:0];
    endfunction

endpackage

// File: rtl/xbar_sw_alloc_if.sv
// Request/grant bundle between the router input stage and the switch allocator.
//   stall        : freeze allocation this cycle
//   req_valid    : per-input request valid
//   req_out_port : per-input requested output, slice [i*LOG_NUM_PORT +: LOG_NUM_PORT]
//   req_tail     : per-input tail-flit flag
//   grant        : per-input combinational grant
//   alloc_vector : registered crossbar connection matrix, bit [i*NUM_CHANNEL+o]
// Modports: master = requester side, slave = allocator side.
interface xbar_sw_alloc_if;
    import xbar_sw_alloc_pkg::*;

    logic                                  stall;
    logic [NUM_CHANNEL-1:0]                req_valid;
    logic [NUM_CHANNEL*LOG_NUM_PORT-1:0]   req_out_port;
    logic [NUM_CHANNEL-1:0]                req_tail;
    logic [NUM_CHANNEL-1:0]                grant;
    logic [NUM_CHANNEL*NUM_CHANNEL-1:0]    alloc_vector;

    modport master (
        output stall, req_valid, req_out_port, req_tail,
        input  grant, alloc_vector
    );

    modport slave (
        input  stall, req_valid, req_out_port, req_tail,
        output grant, alloc_vector
    );

endinterface

// File: rtl/xbar_sw_alloc_rr_arbiter5.sv
// 5-input round-robin arbiter (rrArbiter5).
//   i_req      : candidate mask
//   i_ptr      : highest-priority input (0..4)
//   o_gnt      : one-hot grant, first candidate at or after i_ptr modulo 5
//   o_ptr_next : winner+1 modulo 5, or i_ptr when nothing is granted
module xbar_sw_alloc_rr_arbiter5
    import xbar_sw_alloc_pkg::*;
(
    input  chan_mask_t i_req,
    input  port_t      i_ptr,
    output chan_mask_t o_gnt,
    output port_t      o_ptr_next
);

    logic  w_found;
    port_t w_idx;

    always_comb begin
        o_gnt      = '0;
        o_ptr_next = i_ptr;
        w_found    = 1'b0;
        w_idx      = '0;
        for (int off = 0; off < NUM_CHANNEL; off++) begin
            w_idx = rr_add(i_ptr, port_t'(off));
            if (!w_found && i_req[w_idx]) begin
                w_found      = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_ptr_next   = rr_add(w_idx, port_t'(1));
            end
        end
    end

endmodule

// File: rtl/xbar_sw_alloc.sv
// Round-robin switch allocator for the 5-port crossbar (SA stage of SA->ST).
//   i_clk    : router clock
//   i_reset  : asynchronous active-high reset
//   io_alloc : request/grant bundle (slave modport); grant is combinational,
//              alloc_vector is the registered input->output matrix for the next cycle
// Macro XBAR_ALLOC_LOCK_EN: when defined, a granted non-tail flit locks its output
// to that input until the tail is granted (wormhole switching).
module xbar_sw_alloc
    import xbar_sw_alloc_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    xbar_sw_alloc_if.slave       io_alloc
);

    port_t      w_port     [NUM_CHANNEL];
    chan_mask_t w_req_ok;
    chan_mask_t w_cand     [NUM_CHANNEL];
    chan_mask_t w_arb_gnt  [NUM_CHANNEL];
    port_t      w_ptr_next [NUM_CHANNEL];
    port_t      r_rr_ptr   [NUM_CHANNEL];
    chan_mask_t w_grant;
    logic       w_advance;
    logic [NUM_CHANNEL*NUM_CHANNEL-1:0] w_alloc_d;
    logic [NUM_CHANNEL*NUM_CHANNEL-1:0] r_alloc;

`ifdef XBAR_ALLOC_LOCK_EN
    lock_state_e r_lock  [NUM_CHANNEL];
    port_t       r_owner [NUM_CHANNEL];
    port_t       w_win   [NUM_CHANNEL];
    chan_mask_t  w_busy;
`else
    logic        w_unused_tail;
    assign w_unused_tail = ^io_alloc.req_tail;
`endif

    assign w_advance = !io_alloc.stall && !i_reset;

    // Candidate masks per output. Out-of-range port requests are dropped here.
    always_comb begin
        for (int i = 0; i < NUM_CHANNEL; i++) begin
            w_port[i]   = io_alloc.req_out_port[i*LOG_NUM_PORT +: LOG_NUM_PORT];
            w_req_ok[i] = io_alloc.req_valid[i] && (w_port[i] < port_t'(NUM_CHANNEL));
        end
`ifdef XBAR_ALLOC_LOCK_EN
        // An owner of a locked output may not win any other output.
        w_busy = '0;
        for (int o = 0; o < NUM_CHANNEL; o++) begin
            if (r_lock[o] == LockLocked) begin
                w_busy[r_owner[o]] = 1'b1;
            end
        end
`endif
        for (int o = 0; o < NUM_CHANNEL; o++) begin
            for (int i = 0; i < NUM_CHANNEL; i++) begin
`ifdef XBAR_ALLOC_LOCK_EN
                w_cand[o][i] = w_req_ok[i] && (w_port[i] == port_t'(o)) &&
                               ((r_lock[o] == LockLocked) ? (r_owner[o] == port_t'(i))
                                                          : !w_busy[i]);
`else
                w_cand[o][i] = w_req_ok[i] && (w_port[i] == port_t'(o));
`endif
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNEL; g++) begin : g_arb
        xbar_sw_alloc_rr_arbiter5 u_arb (
            .i_req      (w_cand[g]),
            .i_ptr      (r_rr_ptr[g]),
            .o_gnt      (w_arb_gnt[g]),
            .o_ptr_next (w_ptr_next[g])
        );
    end

    always_comb begin
        w_grant   = '0;
        w_alloc_d = '0;
        for (int o = 0; o < NUM_CHANNEL; o++) begin
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                if (w_advance && w_arb_gnt[o][i]) begin
                    w_grant[i]                 = 1'b1;
                    w_alloc_d[i*NUM_CHANNEL+o] = 1'b1;
                end
            end
        end
    end

    assign io_alloc.grant        = w_grant;
    assign io_alloc.alloc_vector = r_alloc;

    // While locked only the owner can win, so updating on every grant leaves the
    // pointer at owner+1 and is equivalent to updating only on the tail.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_alloc <= '0;
            for (int o = 0; o < NUM_CHANNEL; o++) begin
                r_rr_ptr[o] <= '0;
            end
        end else begin
            r_alloc <= w_alloc_d;
            if (!io_alloc.stall) begin
                for (int o = 0; o < NUM_CHANNEL; o++) begin
                    if (|w_arb_gnt[o]) begin
                        r_rr_ptr[o] <= w_ptr_next[o];
                    end
                end
            end
        end
    end

`ifdef XBAR_ALLOC_LOCK_EN
    always_comb begin
        for (int o = 0; o < NUM_CHANNEL; o++) begin
            w_win[o] = '0;
            for (int i = 0; i < NUM_CHANNEL; i++) begin
                if (w_arb_gnt[o][i]) begin
                    w_win[o] = port_t'(i);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int o = 0; o < NUM_CHANNEL; o++) begin
                r_lock[o]  <= LockIdle;
                r_owner[o] <= '0;
            end
        end else if (!io_alloc.stall) begin
            for (int o = 0; o < NUM_CHANNEL; o++) begin
                unique case (r_lock[o])
                    LockIdle: begin
                        if (|w_arb_gnt[o] && !io_alloc.req_tail[w_win[o]]) begin
                            r_lock[o]  <= LockLocked;
                            r_owner[o] <= w_win[o];
                        end
                    end
                    LockLocked: begin
                        if (|w_arb_gnt[o] && io_alloc.req_tail[r_owner[o]]) begin
                            r_lock[o] <= LockIdle;
                        end
                    end
                    default: r_lock[o] <= LockIdle;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_xbar_sw_alloc.sv
// Scoreboard bench for xbar_sw_alloc: directed scenarios followed by random traffic,
// checked against a per-output round-robin reference model.
module tb_xbar_sw_alloc;
    import xbar_sw_alloc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xbar_sw_alloc_if bus ();

    xbar_sw_alloc dut (
        .i_clk    (clk),
        .i_reset  (reset),
        .io_alloc (bus)
    );

    typedef struct {
        logic [4:0]  grant;
        logic [24:0] alloc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_cnt  = 0;

    // Reference model state
    int          m_ptr    [5];
    bit          m_locked [5];
    int          m_owner  [5];
    logic [24:0] m_alloc_next = '0;

    task automatic step(input bit rst, input bit stl, input logic [4:0] v,
                        input logic [14:0] ports, input logic [4:0] tails);
        exp_t        e;
        int          win [5];
        bit          busy [5];
        logic [4:0]  g;
        logic [24:0] nxt;
        int          idx;
        @(posedge clk);
        #1;
        reset            = rst;
        bus.stall        = stl;
        bus.req_valid    = v;
        bus.req_out_port = ports;
        bus.req_tail     = tails;
        cyc_cnt++;
        e.cyc = cyc_cnt;
        if (rst) begin
            for (int o = 0; o < 5; o++) begin
                m_ptr[o]    = 0;
                m_locked[o] = 1'b0;
                m_owner[o]  = 0;
            end
            m_alloc_next = '0;
            e.grant      = '0;
            e.alloc      = '0;
        end else begin
            g   = '0;
            nxt = '0;
            for (int i = 0; i < 5; i++) busy[i] = 1'b0;
            for (int o = 0; o < 5; o++) if (m_locked[o]) busy[m_owner[o]] = 1'b1;
            for (int o = 0; o < 5; o++) begin
                win[o] = -1;
                for (int k = 0; k < 5; k++) begin
                    idx = (m_ptr[o] + k) % 5;
                    if (v[idx] && ports[idx*3 +: 3] == 3'(o) &&
                        (m_locked[o] ? (idx == m_owner[o]) : !busy[idx])) begin
                        win[o] = idx;
                        break;
                    end
                end
                if (win[o] >= 0 && !stl) begin
                    g[win[o]]         = 1'b1;
                    nxt[win[o]*5 + o] = 1'b1;
                end
            end
            e.grant      = g;
            e.alloc      = m_alloc_next;
            m_alloc_next = nxt;
            if (!stl) begin
                for (int o = 0; o < 5; o++) begin
                    if (win[o] >= 0) begin
                        m_ptr[o] = (win[o] + 1) % 5;
`ifdef XBAR_ALLOC_LOCK_EN
                        if (m_locked[o]) begin
                            if (tails[win[o]]) m_locked[o] = 1'b0;
                        end else if (!tails[win[o]]) begin
                            m_locked[o] = 1'b1;
                            m_owner[o]  = win[o];
                        end
`endif
                    end
                end
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compares DUT outputs mid-cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (bus.grant !== e.grant) begin
                    n_fail++;
                    $display("FAIL grant cyc=%0d got=%b exp=%b", e.cyc, bus.grant, e.grant);
                end
                n_checks++;
                if (bus.alloc_vector !== e.alloc) begin
                    n_fail++;
                    $display("FAIL alloc_vector cyc=%0d got=%h exp=%h",
                             e.cyc, bus.alloc_vector, e.alloc);
                end
            end
        end
    end

    function automatic logic [14:0] all_to(input int p);
        logic [14:0] r;
        for (int i = 0; i < 5; i++) r[i*3 +: 3] = 3'(p);
        return r;
    endfunction

    initial begin
        logic [14:0] p;
        logic [4:0]  t;
        bus.stall        = 1'b0;
        bus.req_valid    = '0;
        bus.req_out_port = '0;
        bus.req_tail     = '0;

        // Reset held
        step(1'b1, 1'b0, 5'h00, '0, '0);
        step(1'b0, 1'b0, 5'h00, '0, '0);

        // All five contend for output 2 with single-flit packets
        for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 5'h1f, all_to(2), 5'h1f);
        step(1'b0, 1'b0, 5'h00, '0, '0);

        // Disjoint: input i -> output (i+1) mod 5
        for (int i = 0; i < 5; i++) p[i*3 +: 3] = 3'((i + 1) % 5);
        step(1'b0, 1'b0, 5'h1f, p, 5'h1f);
        step(1'b0, 1'b0, 5'h00, '0, '0);

        // Inputs 1 (3-flit packet) and 3 both target output 0
        for (int c = 0; c < 4; c++) begin
            t = 5'b01000;
            t[1] = (c == 2);
            step(1'b0, 1'b0, 5'b01010, all_to(0), t);
        end
        step(1'b0, 1'b0, 5'h00, '0, '0);

        // Out-of-range output port
        for (int c = 0; c < 3; c++) step(1'b0, 1'b0, 5'b00100, all_to(6), 5'h1f);

        // Stall with requests, then resume: pointer must be unchanged
        for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 5'h1f, all_to(3), 5'h1f);
        for (int c = 0; c < 2; c++) step(1'b0, 1'b0, 5'h1f, all_to(3), 5'h1f);

        // Reset asserted mid-cycle with requests active, then shared output restarts at 0
        step(1'b1, 1'b0, 5'h1f, all_to(4), 5'h1f);
        step(1'b0, 1'b0, 5'b01001, all_to(4), 5'h1f);
        step(1'b0, 1'b0, 5'b01001, all_to(4), 5'h1f);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 5; i++) p[i*3 +: 3] = 3'($urandom_range(0, 6));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
                 5'($urandom), p, 5'($urandom));
        end
        step(1'b0, 1'b0, 5'h00, '0, '0);

        for (int w = 0; w < 5 && sb.size() > 0; w++) @(negedge clk);
        @(negedge clk);
        if (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/xbar_sw_alloc.md
# xbar_sw_alloc

Round-robin switch allocator for the 5-port crossbar. Each cycle it takes one output-port request per input channel, arbitrates every output among the contending inputs, and returns per-input grants. It then registers the winning input-to-output matrix as the crossbar's `allocVector` for the next cycle. It sits between the router's route-compute/input stage and `Xbar5Ports`, forming the SA stage of a 2-stage SA→ST pipeline.

## Interface
Parameters (from `global.v` macros, not module parameters):
- `NUM_CHANNEL`, 5: input/output channel count.
- `LOG_NUM_PORT`, 3: width of a port index.

Ports:
- `clk`  in  1  router clock.
- `reset`  in  1  asynchronous, active-high reset.
- `stall`  in  1  freeze allocation; no grants this cycle.
- `reqValid`  in  `NUM_CHANNEL`  input i has a flit requesting an output.
- `reqOutPort`  in  `NUM_CHANNEL*LOG_NUM_PORT`  requested output of input i, slice `[i*LOG_NUM_PORT+:LOG_NUM_PORT]`.
- `reqTail`  in  `NUM_CHANNEL`  the requesting flit of input i is a packet tail (single-flit packets assert it).
- `grant`  out  `NUM_CHANNEL`  combinational; input i's flit is accepted this cycle.
- `allocVector`  out  `NUM_CHANNEL*NUM_CHANNEL`  registered; bit `[i*NUM_CHANNEL+o]` connects input i to output o during the following cycle.

One clock and one reset: `reset` is asynchronous and active-high.

## Operation
- **Request mapping:** each input i requests at most one output o = `reqOutPort[i]`. A request with o ≥ `NUM_CHANNEL` is ignored and never granted.
- **Output arbiter:** there is one arbiter per output o. Its candidates are the valid inputs requesting o.
- **Round-robin priority:** pointer `rrPtr[o]` (3 bits, range 0..4) names the highest-priority input. The winner is the first candidate at or after `rrPtr[o]`, searching modulo 5.
- **Pointer update:** on a grant to input k at output o, `rrPtr[o] ← (k+1) mod 5`. The value 4 wraps to 0. While o is locked (see Configuration), the pointer updates only on the tail grant.
- **Grant rules:**
  - `grant[i]=1` iff input i won its requested output and `stall=0` and `reset=0`.
  - At most one grant per output.
  - Each input has only one request, so it receives at most one grant.
- **allocVector:** the next-state value is one bit per granted (i,o) pair, all other bits 0. When `stall=1`, the register loads 0. Every column has at most one bit set, and so does every row.
- **stall:** while `stall=1`, pointers, locks and grants are frozen (grants held at 0).

## Timing
- **SA→ST latency:** a request in cycle N produces `grant` in cycle N (combinational) and a matching `allocVector` in N+1. The flit crosses the crossbar in N+1.
- **Handshake:** the requester holds `reqValid`, `reqOutPort` and `reqTail` stable until it sees `grant`. A flit is consumed in its grant cycle, and the next flit may be presented in N+1.
- **Throughput:** one flit per output per cycle. Back-to-back grants to the same input are allowed.
- **Reset values:** `allocVector=0`, `grant=0`, all `rrPtr=0`, all locks cleared.
- **Reset mid-packet:** locks are dropped. After reset, arbitration restarts from pointer 0.
- **Simultaneous events:** if a tail grant and a new head request for the same output arrive together, the tail wins and the lock is released. The head competes from the next cycle using the updated pointer.
- **All-5-contend case:** if all 5 inputs contend for one output, each input is granted exactly once in 5 consecutive unstalled cycles, provided all packets are single-flit.

## Configuration
- **`XBAR_ALLOC_LOCK_EN` defined (wormhole lock):**
  - Granting a non-tail flit at output o locks o to its input k (owner register plus a lock bit, i.e. state IDLE→LOCKED).
  - While LOCKED, only k is a candidate for o. Other inputs get no grant, even if k is idle that cycle.
  - A tail grant to k returns the output to IDLE.
  - If owner k requests a different output while locked, that request is not granted.
- **`XBAR_ALLOC_LOCK_EN` undefined:**
  - Every flit is arbitrated independently and `reqTail` is ignored.
  - No lock state is synthesized.

## Structure
- `NUM_CHANNEL`, `LOG_NUM_PORT` and the `XBAR_ALLOC_LOCK_EN` default stay in `global.v`.
- One sub-module, `rrArbiter5`: a 5-input round-robin arbiter. It takes a request mask and `rrPtr`, and produces a one-hot grant and the next pointer.
- The allocator instantiates 5 copies of `rrArbiter5` in a generate loop, plus the lock FSMs and the `allocVector` register.

## Test plan
- **Reset:** assert `reset` mid-cycle with requests active → `allocVector`=0 and `grant`=0 immediately; after release, input 0 is granted first on a shared output.
- **Contention:** inputs 0–4 all request output 2, single-flit, for 5 cycles → grants go in the order 0,1,2,3,4. `allocVector` bits 2,7,12,17,22 are set one per cycle, each lagging its grant by 1 cycle.
- **Disjoint requests:** inputs i→output (i+1) mod 5 all valid → all 5 grants in one cycle, and the next-cycle `allocVector` is a full permutation.
- **Lock (`XBAR_ALLOC_LOCK_EN`):**
  - Input 1 sends a 3-flit packet to output 0 while input 3 also requests output 0.
  - Required: input 1 is granted for 3 consecutive cycles, then input 3 is granted.
  - Without the macro: grants alternate 1,3,1,3.
- **Invalid/stall:** `reqOutPort`=6 → never granted. `stall`=1 with requests → no grants, `allocVector`=0, and pointers unchanged after stall drops.
